// File: rtl/conv_pkg.sv
// Shared types and widths for the 3x3 convolution sequencing controller.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN, DRAIN} state_t;

  localparam int PHASES = 4;
  localparam int PH_W   = $clog2(PHASES);
  localparam int DATA_W = 24;
  localparam int RES_W  = 20;
endpackage

// File: rtl/conv_win_addr.sv
// Window row/col counters in raster order plus the pixel-memory address for
// kernel row k of either the current window or, when advancing, the next one.
module conv_win_addr #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        k,
  output logic [ROW_W-1:0]  win_row,
  output logic [COL_W-1:0]  win_col,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 3);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 3);

  logic [ROW_W-1:0] row_reg, row_next, eff_row;
  logic [COL_W-1:0] col_reg, col_next, eff_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (advance) begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  always_comb begin
    row_next = row_reg;
    col_next = col_reg + COL_W'(1);
    if (col_reg == LAST_COL) begin
      col_next = '0;
      row_next = row_reg + ROW_W'(1);
    end
    // The read issued in the accepting cycle already targets the next window.
    eff_row = advance ? row_next : row_reg;
    eff_col = advance ? col_next : col_reg;
    addr    = (ADDR_W'(eff_row) + ADDR_W'(k)) * ADDR_W'(IMG_W) + ADDR_W'(eff_col);
    last    = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
  end

  assign win_row = row_reg;
  assign win_col = col_reg;
endmodule

// File: rtl/conv3x3_ctrl.sv
// Walks every 3x3 window of the image, feeding one kernel row per cycle into a
// free-running 4-phase MAC, and offers each result until it is accepted.
module conv3x3_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      w_we,
  input  logic [1:0]                w_addr,
  input  logic [DATA_W-1:0]         w_data,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [DATA_W-1:0]         mac_data,
  output logic [DATA_W-1:0]         mac_weight,
  input  logic [RES_W-1:0]          mac_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          out_data,
  output logic [$clog2(IMG_H)-1:0]  out_row,
  output logic [$clog2(IMG_W)-1:0]  out_col
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   phase_reg;
  logic              pending_reg, done_reg;
  logic [DATA_W-1:0] weight_reg [3];
  logic              in_run, accept, advance, start_ok, last, feed;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] weight_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_reg + PH_W'(1);
      done_reg  <= (state_reg == DRAIN) && accept;
      if (state_reg == IDLE)
        pending_reg <= 1'b0;
      else if (in_run && phase_reg == 2'd3)
        pending_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_weight
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        weight_reg[gi] <= '0;
      else if (w_we && !busy && !start_ok && w_addr == 2'(gi))
        weight_reg[gi] <= w_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    advance    = 1'b0;
    in_run     = (state_reg == RUN) || (state_reg == DRAIN);
    start_ok   = (state_reg == IDLE) && start && !done_reg;
    out_valid  = in_run && (phase_reg == 2'd0) && pending_reg;
    accept     = out_valid && out_ready;
    case (state_reg)
      IDLE:  if (start_ok) state_next = ALIGN;
      ALIGN: if (phase_reg == 2'd3) state_next = RUN;
      RUN: begin
        rd_en   = (phase_reg != 2'd3);
        advance = accept;
        if (phase_reg == 2'd2 && last) state_next = DRAIN;
      end
      DRAIN: begin
        // A rejected last window is simply read again.
        rd_en = (phase_reg != 2'd3) && !accept;
        if (accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (phase_reg)
      2'd1:    weight_sel = weight_reg[0];
      2'd2:    weight_sel = weight_reg[1];
      2'd3:    weight_sel = weight_reg[2];
      default: weight_sel = '0;
    endcase
  end

  conv_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_win (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg == IDLE),
    .advance(advance),
    .k      (phase_reg),
    .win_row(out_row),
    .win_col(out_col),
    .last   (last),
    .addr   (win_addr)
  );

  assign feed       = in_run && (phase_reg != 2'd0);
  assign mac_data   = feed ? rd_data : '0;
  assign mac_weight = feed ? weight_sel : '0;
  assign rd_addr    = rd_en ? win_addr : '0;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign out_data   = mac_result;
endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Scoreboarded bench: a behavioural pixel memory and 4-phase MAC around the
// controller, expected window results computed directly from image and kernel.
module tb_conv3x3_ctrl;
  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 0, rst = 1, start = 0, w_we = 0, out_ready = 0;
  logic [1:0]  w_addr = 0;
  logic [23:0] w_data = 0, rd_data = 0, mac_data, mac_weight;
  logic        busy, done, rd_en, out_valid;
  logic [7:0]  rd_addr;
  logic [19:0] mac_result, out_data, acc;
  logic [1:0]  out_row, mac_cnt;
  logic [2:0]  out_col;

  logic signed [7:0] img [W*H];
  int kw [3][3];

  typedef struct { int row; int col; int val; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  conv3x3_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      int a;
      a = int'(rd_addr);
      if (a + 2 < W*H) rd_data <= {img[a+2], img[a+1], img[a]};
    end
  end

  function automatic logic [19:0] dot3(input logic [23:0] d, input logic [23:0] w);
    int s = 0;
    for (int j = 0; j < 3; j++) s += int'($signed(d[j*8 +: 8])) * int'($signed(w[j*8 +: 8]));
    return 20'(s);
  endfunction

  // MAC model: phase-0 operand discarded, result updated at end of phase 3.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_cnt <= 0; acc <= 0; mac_result <= 0;
    end else begin
      mac_cnt <= mac_cnt + 2'd1;
      case (mac_cnt)
        2'd0: acc <= 0;
        2'd3: begin mac_result <= acc + dot3(mac_data, mac_weight); acc <= 0; end
        default: acc <= acc + dot3(mac_data, mac_weight);
      endcase
    end
  end

  function automatic int model(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) s += int'(img[(r+k)*W + c + j]) * kw[k][j];
    return s;
  endfunction

  task automatic set_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W+c] = (mode == 0) ? 8'sd1 : (mode == 1) ? 8'(5*r + c) : -8'sd128;
  endtask

  task automatic load_weights(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2);
    logic [23:0] rows [3];
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      w_we = 1; w_addr = 2'(k); w_data = rows[k];
      for (int j = 0; j < 3; j++) kw[k][j] = int'($signed(rows[k][j*8 +: 8]));
    end
    @(negedge clk);
    w_we = 0;
  endtask

  task automatic run_frame(input string name, input int rej_idx, input int rej_n,
                           input int abort_at, input bit disturb);
    int n_exp, accepted = 0, rej_done = 0, offers = 0, cyc = 0, last_offer = -1;
    bit fin = 0, abort_now = 0, last_acc = 0;
    sb.delete();
    for (int r = 0; r <= H-3; r++)
      for (int c = 0; c <= W-3; c++) sb.push_back('{r, c, model(r, c)});
    n_exp = sb.size();
    @(negedge clk);
    start = 1;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 0; w_we = 0; out_ready = 0;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
      end
      if (abort_now) begin
        rst = 1;
        #1;
        checks++;
        if ({busy, done, out_valid, rd_en, rd_addr, mac_data, mac_weight, out_data, out_row, out_col} !== '0) begin
          errors++;
          $display("FAIL %s reset_outputs got busy=%b done=%b valid=%b rd_en=%b addr=%0d mac_d=%h mac_w=%h data=%h row=%0d col=%0d exp=all0",
                   name, busy, done, out_valid, rd_en, rd_addr, mac_data, mac_weight, out_data, out_row, out_col);
        end
        $display("%s: reset applied after %0d accepted results", name, accepted);
        @(negedge clk);
        rst = 0;
        return;
      end
      if (last_acc) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL %s done_pulse got done=%b busy=%b exp done=1 busy=0", name, done, busy);
        end
        fin = 1;
      end else begin
        if (disturb && cyc == 12) begin
          w_we = 1; w_addr = 2'd1; w_data = 24'h7f7f7f; start = 1;
        end
        if (out_valid) begin
          offers++;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s extra_offer got row=%0d col=%0d data=%0d exp=none", name, out_row, out_col, $signed(out_data));
          end else begin
            exp_t e = sb[0];
            checks += 3;
            if (out_data !== 20'(e.val)) begin errors++; $display("FAIL %s data got=%0d exp=%0d", name, $signed(out_data), e.val); end
            if (out_row !== 2'(e.row)) begin errors++; $display("FAIL %s row got=%0d exp=%0d", name, out_row, e.row); end
            if (out_col !== 3'(e.col)) begin errors++; $display("FAIL %s col got=%0d exp=%0d", name, out_col, e.col); end
            if (last_offer >= 0) begin
              checks++;
              if (cyc - last_offer != 4) begin errors++; $display("FAIL %s spacing got=%0d exp=4", name, cyc - last_offer); end
            end
            last_offer = cyc;
            if (accepted == rej_idx && rej_done < rej_n) begin
              rej_done++;
              $display("%s: offer (%0d,%0d)=%0d rejected", name, e.row, e.col, e.val);
            end else begin
              out_ready = 1;
              void'(sb.pop_front());
              accepted++;
              $display("%s: accept (%0d,%0d)=%0d", name, e.row, e.col, e.val);
              if (accepted == n_exp) last_acc = 1;
              if (accepted == abort_at) abort_now = 1;
            end
          end
        end
      end
    end
    out_ready = 0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout accepted=%0d exp=%0d", name, accepted, n_exp);
    end else if (offers != n_exp + rej_n) begin
      errors++; $display("FAIL %s offer_count got=%0d exp=%0d", name, offers, n_exp + rej_n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, out_valid, rd_en, rd_addr, mac_data, mac_weight, out_row, out_col} !== '0) begin
      errors++; $display("FAIL reset_in got busy=%b valid=%b rd_en=%b addr=%0d exp=all0", busy, out_valid, rd_en, rd_addr);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, out_valid, rd_en, mac_data, mac_weight} !== '0) begin
      errors++; $display("FAIL reset_idle got busy=%b done=%b valid=%b rd_en=%b exp=all0", busy, done, out_valid, rd_en);
    end
    $display("reset: idle outputs checked");
  endtask

  task automatic test_ones();
    set_img(0);
    load_weights(24'h010101, 24'h010101, 24'h010101);
    run_frame("ones", -1, 0, -1, 0);
  endtask

  task automatic test_center();
    set_img(1);
    load_weights(24'h000000, 24'h000100, 24'h000000);
    run_frame("center", -1, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 1, 2, -1, 0);
  endtask

  task automatic test_negative();
    set_img(2);
    load_weights(24'h808080, 24'h808080, 24'h808080);
    run_frame("negative", -1, 0, -1, 0);
  endtask

  task automatic test_rst_mid();
    set_img(1);
    load_weights(24'h000000, 24'h000100, 24'h000000);
    run_frame("rst_mid", -1, 0, 2, 0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) kw[k][j] = 0;
    run_frame("after_rst_zero_w", -1, 0, -1, 0);
    load_weights(24'h000000, 24'h000100, 24'h000000);
    run_frame("after_rst", -1, 0, -1, 0);
  endtask

  task automatic test_busy_ignore();
    set_img(1);
    load_weights(24'h010203, 24'hff0102, 24'h0201fe);
    run_frame("busy_ignore", -1, 0, -1, 1);
    run_frame("busy_ignore_recheck", -1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_center();
    test_backpressure();
    test_negative();
    test_rst_mid();
    test_busy_ignore();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv3x3_ctrl.md
# conv3x3_ctrl

Sequencing controller for the 3x3 convolution MAC. It holds the three kernel weight rows and walks every valid 3x3 window of an IMG_H x IMG_W 8-bit signed image in a pixel memory. It feeds one kernel row per cycle into the MAC in lockstep with the MAC's free-running 4-phase accumulate cycle. It presents each 20-bit window result on a valid/ready output with its window coordinates, and re-runs a window until its result is accepted.

## Interface
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- ADDR_W, 8, pixel-memory address width; must hold IMG_H*IMG_W-1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; must be the same rst as the MAC
- start  in  1  one-cycle pulse; begins a frame when idle, ignored when busy
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last window result is accepted
- w_we  in  1  weight row write enable; ignored while busy
- w_addr  in  2  kernel row 0..2 (3 ignored)
- w_data  in  24  {k[r][2], k[r][1], k[r][0]}, signed bytes
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  ADDR_W  row*IMG_W + col
- rd_data  in  24  {p[row][col+2], p[row][col+1], p[row][col]}, valid 1 cycle after rd_en
- mac_data  out  24  MAC data operand
- mac_weight  out  24  MAC weight operand
- mac_result  in  20  signed MAC result
- out_valid  out  1  window result offered
- out_ready  in  1  downstream accepts
- out_data  out  20  signed result (= mac_result)
- out_row  out  $clog2(IMG_H)  window top row
- out_col  out  $clog2(IMG_W)  window left column

## Operation
- The phase counter is 2 bits. It resets to 0 and increments every cycle, mirroring the MAC count. The MAC sums phases 1, 2 and 3 and updates its result at the end of phase 3. The MAC discards its phase-0 operand.
- States:
  - IDLE → ALIGN on start.
  - ALIGN → RUN when phase==3.
  - RUN → DRAIN after the reads for the last window (row IMG_H-3, col IMG_W-3) are issued.
  - DRAIN → IDLE, with done pulsed, when the last result is accepted.
- Read schedule per window, for kernel rows 0, 1, 2:
  - rd_en is high in phases 0, 1 and 2.
  - rd_addr = (win_row + k)*IMG_W + win_col.
- MAC drive:
  - mac_data = rd_data.
  - mac_weight = the weight row for phase-1 (phases 1 to 3).
  - In phase 0 and outside RUN/DRAIN, both are 0.
- out_valid is high only in phase 0 of RUN/DRAIN when a window result is pending. The pending window is the one whose reads were issued in the previous 4-cycle frame.
- Acceptance is decided at phase 0, where out_valid && out_ready means accepted:
  - If accepted, that phase-0 read begins the next window in raster order, col first, then row.
  - If not accepted, the same window is re-read. The identical result is re-offered 4 cycles later and no window is skipped.
  - out_ready → rd_addr is a combinational path, by design.
- In DRAIN no new window starts; a rejected last window is re-read.
- Window count per frame = (IMG_W-2)*(IMG_H-2).
- Weights persist across frames and reset to 0.

## Timing
- Reset values: busy 0, done 0, out_valid 0, rd_en 0, rd_addr 0, mac_data 0, mac_weight 0, out_row 0, out_col 0, state IDLE, weights 0.
- Start to first read: 1–4 cycles (ALIGN waits for phase 3). The first out_valid comes 4 cycles after the first read.
- Steady state with out_ready high: one result every 4 cycles.
- done is asserted in the cycle after the last acceptance, and busy falls in that same cycle.
- start coinciding with done or while busy: ignored.
- A w_we in the same cycle as an accepted start: the write is ignored.
- rst mid-frame: immediately return to reset values. Partial results are discarded and the next start restarts at window (0,0).

## Structure
- Shared package conv_pkg:
  - state enum (IDLE, ALIGN, RUN, DRAIN)
  - PHASES=4
  - DATA_W=24, RES_W=20
- One sub-module, conv_win_addr: window row/col counters with advance/hold, last-window flag, and rd_addr computation.

## Test plan
- IMG_W=5, IMG_H=4, all pixels 1, all weights 1 → 6 results of 9 at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); each exactly 4 cycles apart; then done.
- Pixels p(r,c)=5r+c, weight rows {0,0,0},{0,1,0},{0,0,0} → results 6,7,8,11,12,13.
- Same as above, out_ready low for window (0,1) for two offers → the value 7 is offered 3 times at 4-cycle spacing; the sequence continues with 8; no gaps or duplicates after acceptance.
- All pixels -128, all weights -128 → every result +147456; no overflow.
- rst asserted during the third window → all outputs 0 next cycle; a new start produces the full 6-result sequence from (0,0).
- w_we while busy and start while busy → weights unchanged and the frame uninterrupted; results match the original weights.
